// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: digit count, active-low
// segment patterns ({g,f,e,d,c,b,a}) and the scan state encoding.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    typedef enum logic {
        GUARD = 1'b0,
        ON    = 1'b1
    } scan_state_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show blank.
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment scan driver with guard gaps.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_LAST   = cnt_t'(CLK_DIV - 1);
    localparam cnt_t GUARD_LAST = cnt_t'(BLANK_CYCLES - 1);

    logic [NUM_DIGITS-1:0][3:0] r_pend;
    logic [NUM_DIGITS-1:0][3:0] r_shad;
    logic                       r_pend_v;
    cnt_t                       r_div_cnt;
    logic [1:0]                 r_sel;
    scan_state_e                r_state;
    logic [3:0]                 r_an;
    logic [6:0]                 r_seg;
    logic                       r_frame_done;

    logic [NUM_DIGITS-1:0][3:0] w_din;
    logic [NUM_DIGITS-1:0][3:0] w_shad_nxt;
    logic                       w_wrap;
    cnt_t                       w_div_nxt;
    logic [1:0]                 w_sel_nxt;
    scan_state_e                w_state_nxt;
    logic [6:0]                 w_dec_seg;
    logic                       w_lzb;
    logic                       w_show;

    assign w_din  = {d3, d2, d1, d0};
    assign w_wrap = (r_state == ON) && (r_div_cnt == CNT_LAST) && (r_sel == 2'd3);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt + 1'b1;
        w_sel_nxt   = r_sel;
        case (r_state)
            GUARD: if (r_div_cnt == GUARD_LAST) w_state_nxt = ON;
            ON: begin
                if (r_div_cnt == CNT_LAST) begin
                    w_div_nxt   = '0;
                    w_sel_nxt   = r_sel + 2'd1;
                    w_state_nxt = GUARD;
                end
            end
            default: w_state_nxt = GUARD;
        endcase
    end

    // Shadow digits only change at the frame wrap so a frame never tears;
    // a load coinciding with the wrap bypasses the pending buffer.
    always_comb begin
        w_shad_nxt = r_shad;
        if (w_wrap) begin
            if (load)
                w_shad_nxt = w_din;
            else if (r_pend_v)
                w_shad_nxt = r_pend;
        end
    end

    bcd_to_7seg u_dec (
        .i_bcd (w_shad_nxt[w_sel_nxt]),
        .o_seg (w_dec_seg)
    );

`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        w_lzb = 1'b0;
        case (w_sel_nxt)
            2'd3:    w_lzb = (w_shad_nxt[3] == 4'd0);
            2'd2:    w_lzb = (w_shad_nxt[3] == 4'd0) && (w_shad_nxt[2] == 4'd0);
            2'd1:    w_lzb = (w_shad_nxt[3] == 4'd0) && (w_shad_nxt[2] == 4'd0)
                             && (w_shad_nxt[1] == 4'd0);
            default: w_lzb = 1'b0;
        endcase
    end
`else
    assign w_lzb = 1'b0;
`endif

    assign w_show = (w_state_nxt == ON) && !w_lzb;

    // Outputs are computed from next-state values so an and seg switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend       <= '0;
            r_shad       <= '0;
            r_pend_v     <= 1'b0;
            r_div_cnt    <= '0;
            r_sel        <= 2'd0;
            r_state      <= GUARD;
            r_an         <= 4'b1111;
            r_seg        <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_nxt;
            r_sel     <= w_sel_nxt;
            r_shad    <= w_shad_nxt;
            if (load)
                r_pend <= w_din;
            if (w_wrap)
                r_pend_v <= 1'b0;
            else if (load)
                r_pend_v <= 1'b1;
            r_an         <= w_show ? ~(4'b0001 << w_sel_nxt) : 4'b1111;
            r_seg        <= w_show ? w_dec_seg : SEG_BLANK;
            r_frame_done <= (w_state_nxt == ON) && (w_div_nxt == CNT_LAST)
                            && (w_sel_nxt == 2'd3);
        end
    end

    assign sel        = r_sel;
    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan driver for a 4-digit common-anode 7-segment display. It holds four BCD digits in shadow registers and steps the 2-bit digit select through 0→1→2→3→0. It decodes the selected digit and drives active-low anode enables, with a guard gap between digits to suppress ghosting. It sits upstream of the display pins and replaces a manually driven selector in the 4:1 digit-mux / BCD-decode path.

## Interface
- CLK_DIV, 100000: total clock cycles each digit occupies (guard + on); minimum 4
- BLANK_CYCLES, 16: guard cycles at the start of each digit slot with all anodes off; 1 ≤ BLANK_CYCLES < CLK_DIV
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  capture strobe for d0..d3, sampled every clk
- d0, d1, d2, d3  in  4 each  BCD digits; d0 is rightmost
- sel  out  2  index of the digit slot currently active
- an  out  4  anode enables, active-low, one-hot-low during the on phase; an[k] ↔ dk
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- frame_done  out  1  one-cycle pulse at the end of digit 3's slot

## Operation
- Registers:
  - pend[0:3]: pending digit data
  - shad[0:3]: displayed digit data
  - pend_v: pending-valid flag
  - div_cnt: 0..CLK_DIV-1
  - sel
  - state ∈ {GUARD, ON}
- load=1: pend ← d0..d3 and pend_v ← 1.
- At frame wrap (sel 3→0): if pend_v, shad ← pend and pend_v ← 0.
- load=1 on the wrap edge: shad ← d0..d3 directly and pend_v stays 0. No tearing occurs within a frame.
- GUARD:
  - an=4'b1111 and seg=7'b1111111.
  - When div_cnt reaches BLANK_CYCLES-1 → ON.
- ON:
  - an[sel]=0, all other anodes 1.
  - seg=decode(shad[sel]).
  - When div_cnt reaches CLK_DIV-1: div_cnt←0, sel←sel+1 (mod 4), → GUARD.
  - If sel was 3, frame_done=1 for that cycle.
- Decode: 0–9 use standard patterns (0→7'b1000000, 1→7'b1111001, 8→7'b0000000). Values 10–15 decode to blank (7'b1111111) and the anode is still enabled.
- Reset values:
  - sel=0, an=4'b1111, seg=7'b1111111, frame_done=0
  - state=GUARD, div_cnt=0
  - shad and pend all 0, pend_v=0
- Reset asserted mid-frame forces the reset values immediately, with no completion of the current slot. After release, the scan restarts at digit 0 GUARD.

## Timing
- All outputs are registered. an and seg change on the same clk edge, so there is no cycle where a new anode shows the old pattern.
- Digit slot = CLK_DIV cycles: BLANK_CYCLES guard, then CLK_DIV-BLANK_CYCLES on. Frame = 4·CLK_DIV cycles.
- First ON after reset release: an=4'b1110 on the edge ending cycle BLANK_CYCLES.
- Load-to-display latency: new data is visible from the first digit-0 ON of the next frame. Worst case is about 4·CLK_DIV + BLANK_CYCLES cycles.
- frame_done asserts in the last ON cycle of digit 3 and deasserts on the next edge.

## Configuration
- SEG_SCAN_LZB_EN defined: leading-zero blanking.
  - Digit 3 is blanked if shad[3]==0.
  - Digit 2 is blanked if shad[3]==0 and shad[2]==0.
  - Digit 1 is blanked if shad[3..1] are all 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps an=4'b1111 during its ON phase. Slot timing and frame_done are unchanged.
- Not defined: all four digits are always shown, including leading zeros.

## Structure
- Package seg_pkg holds:
  - constant NUM_DIGITS=4
  - the 10 digit segment patterns and SEG_BLANK=7'b1111111
  - the scan state enum {GUARD, ON}
- Sub-module bcd_to_7seg: combinational 4-bit → 7-bit active-low decoder with the blank rule for 10–15. It is instantiated once, on the shad[sel] path.

## Test plan
- Reset and scan, CLK_DIV=8, BLANK_CYCLES=2, shad=0 → an sequence 1111(2 cycles), 1110(6), 1111(2), 1101(6)…; sel 0,1,2,3,0; frame_done high exactly every 32 cycles.
- Load d0..d3=1,2,3,4 mid-frame at digit 1 → current frame still shows 0s; next frame shows seg 1111001 on an=1110 and 0011001 on an=0111.
- Load exactly on the wrap edge with d=9,9,9,9 → digit 0 of that same frame shows 0010000; pend_v stays 0.
- d2=4'hC → digit 2 slot has an=1011 and seg=1111111.
- Async reset asserted during digit 2 ON → outputs go immediately to an=1111, seg=1111111, sel=0; scan restarts at GUARD of digit 0 after release.
- With SEG_SCAN_LZB_EN, load 0,0,5,0 (d3..d0 = 0,0,5,0 → shown "50") → digits 3 and 2 keep an=1111 throughout; digit 1 shows 5 (0010010); digit 0 shows 0.
